keypad_scan: RTL and testbench



---
 rtl/keypad_scan_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/keypad_scan.sv | 132 +++++++++++++
 tb/tb_keypad_scan.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_pkg.sv
// Shared constants, key payload type and row-decode helper for the keypad scanner.
package keypad_pkg;

    localparam int unsigned KEY_VALID_BIT = 4;
    localparam int unsigned KEY_W         = 5;
    localparam int unsigned NUM_COLS      = 4;
    localparam int unsigned NUM_ROWS      = 4;

    localparam logic [KEY_W-1:0] KEY_NONE    = 5'h00;
    localparam logic [KEY_W-1:0] KEY_GUN_INC = 5'h11;
    localparam logic [KEY_W-1:0] KEY_GUN_DEC = 5'h13;
    localparam logic [KEY_W-1:0] KEY_FIRE    = 5'h15;

    typedef struct packed {
        logic       valid;
        logic [1:0] col;
        logic [1:0] row;
    } key_code_t;

    // Returns {hit, index} of the lowest-numbered row pulled low.
    function automatic logic [2:0] row_decode(input logic [NUM_ROWS-1:0] rows);
        logic [2:0] res;
        res = 3'b000;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the 4 keypad row inputs; idles high like the pulled-up rows.
module sync_2ff (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_d,
    output logic [3:0] o_q
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 4'hF;
            r_sync <= 4'hF;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with scan-level debounce and one-cycle key pulses.
// Optional auto-repeat of the held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 12500,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [4:0] key,
    output logic [4:0] key_pulse
);

    localparam int unsigned DIV_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned STAB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_FULL = STAB_W'(DEBOUNCE_SCANS);

    logic [DIV_W-1:0]  r_div_cnt;
    logic [1:0]        r_col;
    logic [3:0]        r_key_col;
    logic [3:0]        w_row_sync;
    logic [2:0]        w_row_hit;
    logic              w_slot_end;
    logic              w_scan_done;
    logic              w_key_update;
    key_code_t         w_raw;
    key_code_t         r_acc;
    key_code_t         r_cand;
    logic [STAB_W-1:0] r_stab_cnt;
    logic [4:0]        r_key;
    logic [4:0]        r_key_pulse;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_W = (REPEAT_SCANS > 2) ? $clog2(REPEAT_SCANS) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
    logic [REP_W-1:0] r_rep_cnt;
`else
    logic [31:0] w_rep_unused;
    assign w_rep_unused = 32'(REPEAT_SCANS);
`endif

    sync_2ff u_row_sync (
        .clk   (clk),
        .rst_n (rst),
        .i_d   (key_row),
        .o_q   (w_row_sync)
    );

    assign w_slot_end   = (r_div_cnt == DIV_LAST);
    assign w_scan_done  = w_slot_end && (r_col == 2'd3);
    assign w_row_hit    = row_decode(w_row_sync);
    assign w_key_update = (r_stab_cnt == STAB_FULL) && (5'(r_cand) != r_key);

    // Scan result so far including the current slot; earlier slots keep priority.
    always_comb begin
        w_raw = r_acc;
        if (!r_acc.valid && w_row_hit[2]) begin
            w_raw = key_code_t'({1'b1, r_col, w_row_hit[1:0]});
        end
    end

    // Slot prescaler and one-hot active-low column drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
            r_col     <= 2'd0;
            r_key_col <= 4'b1110;
        end else if (w_slot_end) begin
            r_div_cnt <= '0;
            r_col     <= r_col + 2'd1;
            r_key_col <= ~(4'b0001 << (r_col + 2'd1));
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Per-scan accumulation and scan-level debounce of the candidate code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc      <= '0;
            r_cand     <= '0;
            r_stab_cnt <= '0;
        end else if (w_slot_end) begin
            r_acc <= w_scan_done ? key_code_t'(KEY_NONE) : w_raw;
            if (w_scan_done) begin
                if (w_raw == r_cand) begin
                    if (r_stab_cnt != STAB_FULL) r_stab_cnt <= r_stab_cnt + STAB_W'(1);
                end else begin
                    r_cand     <= w_raw;
                    r_stab_cnt <= STAB_W'(1);
                end
            end
        end
    end

    // Debounced key level and single-cycle pulse; a key change overrides a repeat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key       <= KEY_NONE;
            r_key_pulse <= KEY_NONE;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= '0;
`endif
        end else begin
            r_key_pulse <= KEY_NONE;
            if (w_key_update) begin
                r_key <= r_cand;
                if (r_cand.valid) r_key_pulse <= r_cand;
`ifdef KEYPAD_REPEAT_EN
                r_rep_cnt <= '0;
            end else if (w_scan_done && r_key[KEY_VALID_BIT]) begin
                if (r_rep_cnt == REP_LAST) begin
                    r_rep_cnt   <= '0;
                    r_key_pulse <= r_key;
                end else begin
                    r_rep_cnt <= r_rep_cnt + REP_W'(1);
                end
`endif
            end
        end
    end

    assign key_col   = r_key_col;
    assign key       = r_key;
    assign key_pulse = r_key_pulse;

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized self-checking bench for keypad_scan against a scan-level keypad model.
// Honours KEYPAD_REPEAT_EN in the model when the design is built with it.
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int REP      = 2;
    localparam int SCAN_CYC = 4 * SCAN_DIV;
`ifdef KEYPAD_REPEAT_EN
    localparam int REL_PULSES = 2;
    localparam int REP_PULSES = 4;
`else
    localparam int REL_PULSES = 0;
    localparam int REP_PULSES = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [4:0]  key;
    logic [4:0]  key_pulse;
    logic [15:0] key_mask;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulse  = 0;

    // Reference state
    int         p;
    logic [4:0] exp_key;
    logic [4:0] exp_pulse;
    logic [3:0] exp_col;
    logic [4:0] hist[$];
    logic       pend;
    logic [4:0] pend_val;
    int         rep_n;

    keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB),
        .REPEAT_SCANS   (REP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .key       (key),
        .key_pulse (key_pulse)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key at (c, r) pulls row r low while column c is driven.
    always_comb begin
        key_row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!key_col[c] && key_mask[c*4+r]) key_row[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, p);
    endtask

    function automatic logic [4:0] scan_result(input logic [15:0] m);
        for (int i = 0; i < 16; i++)
            if (m[i]) return {1'b1, 4'(i)};
        return 5'h00;
    endfunction

    function automatic logic last_deb_equal();
        if (hist.size() < DEB) return 1'b0;
        for (int i = hist.size() - DEB; i < hist.size(); i++)
            if (hist[i] != hist[hist.size()-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        p = 0; exp_key = 5'h00; exp_pulse = 5'h00; exp_col = 4'b1110;
        hist.delete(); pend = 1'b0; pend_val = 5'h00; rep_n = 0;
    endtask

    // Scan-level behaviour: one result per full scan, key follows DEB equal results.
    task automatic model_edge();
        logic [3:0] onehot;
        exp_pulse = 5'h00;
        onehot    = 4'b0001 << ((p / SCAN_DIV) % 4);
        exp_col   = ~onehot;
        if (p % SCAN_CYC == 0) begin
            hist.push_back(scan_result(key_mask));
            if (hist.size() > DEB) void'(hist.pop_front());
`ifdef KEYPAD_REPEAT_EN
            if (exp_key[4]) begin
                rep_n++;
                if (rep_n == REP) begin
                    exp_pulse = exp_key;
                    rep_n = 0;
                end
            end
`endif
            if (last_deb_equal() && hist[hist.size()-1] != exp_key) begin
                pend     = 1'b1;
                pend_val = hist[hist.size()-1];
            end
        end else if (p % SCAN_CYC == 1 && pend) begin
            exp_key = pend_val;
            if (pend_val[4]) exp_pulse = pend_val;
            rep_n = 0;
            pend  = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        p++;
        model_edge();
        #1;
        chk("key_col", 32'(key_col), 32'(exp_col));
        chk("key", 32'(key), 32'(exp_key));
        chk("key_pulse", 32'(key_pulse), 32'(exp_pulse));
        if (key_pulse != 5'h00) n_pulse++;
    endtask

    task automatic run_scans(input logic [15:0] m, input int n);
        key_mask = m;
        repeat (n * SCAN_CYC) step();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            chk("rst_key_col", 32'(key_col), 32'h0000_000E);
            chk("rst_key", 32'(key), 32'h0);
            chk("rst_key_pulse", 32'(key_pulse), 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        model_clear();
    endtask

    initial begin
        logic [15:0] m;
        logic [15:0] one;
        rst      = 1'b0;
        key_mask = 16'h0000;
        one      = 16'h0001;
        model_clear();

        do_reset(5);
        run_scans(16'h0000, 2);

        // Single press of code 5 (col 1, row 1), then release
        n_pulse = 0;
        run_scans(16'h0020, 4);
        chk("press_key", 32'(key), 32'h15);
        chk("press_pulses", 32'(n_pulse), 32'd1);
        n_pulse = 0;
        run_scans(16'h0000, 4);
        chk("release_key", 32'(key), 32'h0);
        chk("release_pulses", 32'(n_pulse), 32'(REL_PULSES));

        // Bounce: code 3 present only every other scan
        do_reset(2);
        n_pulse = 0;
        for (int i = 0; i < 3; i++) begin
            run_scans(16'h0008, 1);
            run_scans(16'h0000, 1);
        end
        chk("bounce_key", 32'(key), 32'h0);
        chk("bounce_pulses", 32'(n_pulse), 32'd0);

        // Priority: codes 1 and 3 together, then code 1 released
        run_scans(16'h000A, 4);
        chk("prio_key", 32'(key), 32'h11);
        run_scans(16'h0008, 4);
        chk("prio_next_key", 32'(key), 32'h13);
        run_scans(16'h0000, 4);

        // Long hold of code 1
        do_reset(2);
        n_pulse = 0;
        run_scans(16'h0002, 9);
        chk("repeat_pulses", 32'(n_pulse), 32'(REP_PULSES));
        run_scans(16'h0000, 4);

        // Reset one clock before the debounce count would complete
        do_reset(2);
        n_pulse  = 0;
        key_mask = 16'h0020;
        repeat (3 * SCAN_CYC - 1) step();
        do_reset(2);
        chk("midrst_pulses", 32'(n_pulse), 32'd0);
        chk("midrst_key", 32'(key), 32'h0);
        run_scans(16'h0020, 4);
        run_scans(16'h0000, 4);

        // Randomized press patterns with random hold lengths
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 2))
                0:       m = 16'h0000;
                1:       m = one << $urandom_range(0, 15);
                default: m = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
            endcase
            run_scans(m, $urandom_range(1, 5));
        end
        run_scans(16'h0000, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
